// File: rtl/digdug_dev_responder.sv
// digdug_dev_responder: target end of the shared DigDug CPU device bus.
//   Decodes arbiter DEV_* requests into work RAM, main control latch,
//   video latch, watchdog and the forwarded custom-I/O window.
// Ports:
//   clk_i, rst_ni            device bus clock, async active-low reset
//   dev_ad_i/rd_i/wr_i/di_i  bus request (level RD/WR, sampled every clk)
//   dev_dv_o/do_o            read data valid / read data (0 when not valid)
//   ext_ad_o/rd_o/wr_o/di_o  custom-I/O request, one-cycle strobes
//   ext_dv_i/do_i            custom-I/O read response
//   irq_en_o, nmi2_en_o, sub_reset_o  decoded main latch bits
//   vid_latch_o              video latch 0xA000-0xA007 bit0
//   wdog_rst_o               watchdog reset pulse
// Optional feature: define DIGDUG_DEV_WDOG_EN to enable the watchdog counter.
module digdug_dev_responder #(
    parameter int unsigned RAM_AW   = 11,
    parameter logic [19:0] WDOG_MAX = 20'hFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] dev_ad_i,
    input  logic        dev_rd_i,
    input  logic        dev_wr_i,
    input  logic [7:0]  dev_di_i,
    output logic        dev_dv_o,
    output logic [7:0]  dev_do_o,
    output logic [7:0]  ext_ad_o,
    output logic        ext_rd_o,
    output logic        ext_wr_o,
    output logic [7:0]  ext_di_o,
    input  logic        ext_dv_i,
    input  logic [7:0]  ext_do_i,
    output logic [1:0]  irq_en_o,
    output logic        nmi2_en_o,
    output logic        sub_reset_o,
    output logic [7:0]  vid_latch_o,
    output logic        wdog_rst_o
);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e      state_q, state_d;
    logic [7:0]  latch_q, latch_d, vid_q, vid_d, do_q, do_d;
    logic [7:0]  ext_ad_q, ext_ad_d, ext_di_q, ext_di_d, ram_q;
    logic        dv_q, dv_d, ram_dv_q, ram_dv_d, ext_rd_q, ext_rd_d, ext_wr_q, ext_wr_d;
    logic [3:0]  tmo_q, tmo_d;
    logic [7:0]  mem [2**RAM_AW];
    logic        is_latch, is_ext, is_ram, is_vid, rd;

    assign is_latch = dev_ad_i >= 16'h6800 && dev_ad_i <= 16'h6827;
    assign is_ext   = dev_ad_i[15:9] == 7'h38;
    assign is_ram   = dev_ad_i[15:13] == 3'b100;
    assign is_vid   = dev_ad_i[15:3] == 13'h1400;
    // a simultaneous write wins, so a read only counts with WR low
    assign rd       = dev_rd_i & ~dev_wr_i;

    always_ff @(posedge clk_i) begin
        if (dev_wr_i && is_ram) mem[dev_ad_i[RAM_AW-1:0]] <= dev_di_i;
        ram_q <= mem[dev_ad_i[RAM_AW-1:0]];
    end

    always_comb begin
        state_d  = state_q;
        latch_d  = latch_q;
        vid_d    = vid_q;
        tmo_d    = tmo_q;
        ext_ad_d = ext_ad_q;
        ext_di_d = ext_di_q;
        ext_rd_d = 1'b0;
        ext_wr_d = 1'b0;
        dv_d     = 1'b0;
        do_d     = 8'h00;
        ram_dv_d = rd & is_ram;
        if (dev_wr_i && is_latch) latch_d[dev_ad_i[2:0]] = dev_di_i[0];
        if (dev_wr_i && is_vid) vid_d[dev_ad_i[2:0]] = dev_di_i[0];
        if (rd && is_latch) begin
            dv_d = 1'b1;
            do_d = {7'b0, latch_q[dev_ad_i[2:0]]};
        end
        if (state_q == IDLE) begin
            tmo_d = 4'd0;
            if (is_ext && (dev_rd_i || dev_wr_i)) begin
                ext_ad_d = dev_ad_i[7:0];
                ext_di_d = dev_di_i;
                ext_wr_d = dev_wr_i;
                ext_rd_d = ~dev_wr_i;
                state_d  = dev_wr_i ? IDLE : WAIT;
            end
        end else if (ext_dv_i || tmo_q == 4'hF) begin
            // the external response owns the return path this cycle
            dv_d     = 1'b1;
            do_d     = ext_dv_i ? ext_do_i : 8'hFF;
            ram_dv_d = 1'b0;
            state_d  = IDLE;
        end else begin
            tmo_d = tmo_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            latch_q  <= '0;
            vid_q    <= '0;
            tmo_q    <= '0;
            ext_ad_q <= '0;
            ext_di_q <= '0;
            ext_rd_q <= 1'b0;
            ext_wr_q <= 1'b0;
            dv_q     <= 1'b0;
            do_q     <= '0;
            ram_dv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            latch_q  <= latch_d;
            vid_q    <= vid_d;
            tmo_q    <= tmo_d;
            ext_ad_q <= ext_ad_d;
            ext_di_q <= ext_di_d;
            ext_rd_q <= ext_rd_d;
            ext_wr_q <= ext_wr_d;
            dv_q     <= dv_d;
            do_q     <= do_d;
            ram_dv_q <= ram_dv_d;
        end
    end

    assign dev_dv_o    = dv_q | ram_dv_q;
    assign dev_do_o    = ram_dv_q ? ram_q : dv_q ? do_q : 8'h00;
    assign ext_ad_o    = ext_ad_q;
    assign ext_di_o    = ext_di_q;
    assign ext_rd_o    = ext_rd_q;
    assign ext_wr_o    = ext_wr_q;
    assign irq_en_o    = latch_q[1:0];
    assign nmi2_en_o   = ~latch_q[2];
    assign sub_reset_o = ~latch_q[3];
    assign vid_latch_o = vid_q;

`ifdef DIGDUG_DEV_WDOG_EN
    logic [19:0] wdog_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wdog_q <= '0;
        else wdog_q <= ((dev_wr_i && dev_ad_i == 16'h6830) || wdog_q == WDOG_MAX) ? '0 : wdog_q + 20'd1;
    end
    assign wdog_rst_o = wdog_q == WDOG_MAX;
`else
    // counter absent; the reduction only keeps WDOG_MAX referenced
    assign wdog_rst_o = &{1'b0, WDOG_MAX};
`endif
endmodule

// File: doc/digdug_dev_responder.md
Name: digdug_dev_responder

Overview:
- Target end of the shared CPU device bus: decodes each DEV_* request issued by the three-CPU bus arbiter and returns DEV_DV/DEV_DO.
- Holds shared work RAM, main control latch (IRQ/NMI enables, sub-CPU reset), video latch and watchdog.
- Forwards the custom-I/O window to an external port with its own valid handshake.
- Sits between the CPU arbiter and the video/IO sections of the DigDug top level.

Parameters:
- RAM_AW, 11: work RAM address width; RAM is 2^RAM_AW bytes mirrored across 0x8000-0x9FFF.
- WDOG_MAX, 20'hFFFFF: watchdog terminal count (only with WDOG_EN).

Ports:
- CLK  in  1  device bus clock (the arbiter's 24 MHz DEV_CL)
- RESET_N  in  1  asynchronous active-low reset
- DEV_AD  in  16  request address
- DEV_RD  in  1  read request, level, sampled every CLK
- DEV_WR  in  1  write request, level, sampled every CLK
- DEV_DI  in  8  write data
- DEV_DV  out  1  read data valid
- DEV_DO  out  8  read data
- EXT_AD  out  8  custom-I/O offset (DEV_AD[7:0])
- EXT_RD  out  1  custom-I/O read strobe
- EXT_WR  out  1  custom-I/O write strobe
- EXT_DI  out  8  custom-I/O write data
- EXT_DV  in  1  custom-I/O read data valid
- EXT_DO  in  8  custom-I/O read data
- IRQ_EN  out  2  latch bits 0x6820/0x6821 (CPU0, CPU1 IRQ enable)
- NMI2_EN  out  1  inverse of latch 0x6822 bit0
- SUB_RESET  out  1  inverse of latch 0x6823 bit0 (high holds CPU1/CPU2 in reset)
- VID_LATCH  out  8  bit0 of each of 0xA000-0xA007
- WDOG_RST  out  1  watchdog reset pulse

Behaviour:
- Decode on DEV_AD, sampled at rising CLK:
  - 0x6800-0x681F, 0x6820-0x6827: main latch; write bit0 to index AD[2:0]; readback = {7'b0, bit}.
  - 0x6830: watchdog kick, write only.
  - 0x7000-0x71FF: custom-I/O window.
  - 0x8000-0x9FFF: work RAM, index AD[RAM_AW-1:0].
  - 0xA000-0xA007: video latch, write only.
  - Anything else, including ROM space 0x0000-0x3FFF, is ignored: no write, DEV_DV stays 0.
- Writes take effect at the CLK edge where DEV_WR=1; repeated cycles within one arbiter slot rewrite the same value (idempotent).
- DEV_RD and DEV_WR both high: the write wins and no DV is produced.
- RAM and latch reads: 1-cycle pipeline. The address sampled at edge N yields DEV_DV=1 and DEV_DO valid after edge N+1. DV is produced for every cycle RD is high.
- Custom-I/O window, 2-state FSM IDLE/WAIT:
  - IDLE: on RD or WR in window, register EXT_AD/EXT_DI and assert EXT_RD or EXT_WR for exactly one CLK. A write returns to IDLE; a read goes to WAIT.
  - WAIT: hold until EXT_DV=1, then DEV_DV=1, DEV_DO=EXT_DO for one CLK, return to IDLE.
  - New window requests while in WAIT are dropped, not queued.
  - WAIT times out after 16 CLK: return to IDLE, DEV_DV=1, DEV_DO=8'hFF.
- DEV_DO = 8'h00 whenever DEV_DV=0.
- Reset values:
  - DEV_DV=0, DEV_DO=0, EXT_RD=0, EXT_WR=0, EXT_AD=0, EXT_DI=0.
  - Latch bits all 0, so IRQ_EN=0, NMI2_EN=1, SUB_RESET=1.
  - VID_LATCH=0, WDOG_RST=0, FSM=IDLE.
  - RAM contents undefined.
- Reset asserted mid-transaction: FSM returns to IDLE immediately; a pending EXT read is abandoned and no DV is produced after release.

Optional Feature:
- Macro DIGDUG_DEV_WDOG_EN.
- Defined: 20-bit counter increments every CLK and clears on any write to 0x6830. On reaching WDOG_MAX, WDOG_RST=1 for exactly one CLK and the counter wraps to 0.
- Not defined: no counter, WDOG_RST tied 0, and writes to 0x6830 are ignored.

Test Plan:
- Reset release: NMI2_EN=1, SUB_RESET=1, IRQ_EN=2'b00, DEV_DV=0. Write 0x01 to 0x6823 -> SUB_RESET=0 the next cycle; read 0x6823 -> DEV_DV=1, DEV_DO=8'h01 one cycle after RD.
- Write 0x5A to 0x8000 and 0xA5 to 0x87FF, then read both plus mirror 0x8800 -> 8'h5A, 8'hA5, 8'h5A, each 1-cycle latency.
- Read 0x1234 (ROM space) and 0xC000 -> DEV_DV stays 0 for 4 cycles; RAM contents unchanged.
- Read 0x7100 -> EXT_RD pulses 1 cycle with EXT_AD=8'h00. EXT_DV at +3 cycles with 8'h3C -> DEV_DV=1, DEV_DO=8'h3C next cycle. Repeat with no EXT_DV -> DEV_DO=8'hFF after 16 cycles.
- Assert RESET_N=0 while FSM is in WAIT, release, then drive EXT_DV=1 -> no DEV_DV; FSM accepts a new 0x7000 write (EXT_WR pulse).
- With DIGDUG_DEV_WDOG_EN and WDOG_MAX=100: no kicks -> WDOG_RST 1-cycle pulse at cycle 100. Kick at cycle 50 -> pulse delayed to cycle 150.
